// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register command sequencer:
// opcodes, mux select encodings, FSM state encoding and opcode helpers.
package usr_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op >= OP_SHR) && (op <= OP_ROL);
  endfunction

  function automatic logic is_illegal_op(input logic [2:0] op);
    return op > OP_ROL;
  endfunction

endpackage

// File: rtl/usr_step_counter.sv
// Loadable down-counter tracking remaining shift positions; term flags the
// final step so the FSM can leave SHIFT on that same strobe edge.
module usr_step_counter #(
  parameter int CNT_WIDTH = 3
) (
  input  logic                 i_clk,
  input  logic                 clr,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 dec,
  output logic                 term
);

  logic [CNT_WIDTH-1:0] remaining_reg;

  always_ff @(posedge i_clk or negedge clr) begin
    if (!clr) begin
      remaining_reg <= '0;
    end else if (load) begin
      remaining_reg <= load_val;
    end else if (dec && (remaining_reg != '0)) begin
      remaining_reg <= remaining_reg - CNT_WIDTH'(1);
    end
  end

  assign term = (remaining_reg == CNT_WIDTH'(1));

endmodule

// File: rtl/usr_cmd_sequencer.sv
// Command sequencer for a 4:1-mux universal shift register: accepts one
// command, then steers mux select, serial fill and parallel data per strobe.
module usr_cmd_sequencer
  import usr_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int DATA_WIDTH1 = 2,
  parameter int CNT_WIDTH   = 3
) (
  input  logic                   i_clk,
  input  logic                   clr,
  input  logic                   step_en,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [CNT_WIDTH-1:0]   cmd_cnt,
  input  logic [DATA_WIDTH-1:0]  cmd_data,
  input  logic                   cmd_fill,
  input  logic [DATA_WIDTH-1:0]  q_in,
  output logic [DATA_WIDTH1-1:0] sel_mux,
  output logic                   sr,
  output logic                   sl,
  output logic [DATA_WIDTH-1:0]  par_in,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_t                state_reg;
  logic [2:0]            op_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  fill_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  err_reg;
  logic                  accept;
  logic                  shift_step;
  logic                  term;
  logic                  load_strobe;
  logic                  unused_q_mid;

  assign accept     = (state_reg == ST_IDLE) && cmd_valid;
  assign shift_step = (state_reg == ST_SHIFT) && step_en;

  usr_step_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_step_counter (
    .i_clk   (i_clk),
    .clr     (clr),
    .load    (accept),
    .load_val(cmd_cnt),
    .dec     (shift_step),
    .term    (term)
  );

  always_ff @(posedge i_clk or negedge clr) begin
    if (!clr) begin
      state_reg <= ST_IDLE;
      op_reg    <= OP_NOP;
      data_reg  <= '0;
      fill_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_reg   <= cmd_op;
            data_reg <= cmd_data;
            fill_reg <= cmd_fill;
            if (cmd_op == OP_LOAD) begin
              state_reg <= ST_LOAD;
              busy_reg  <= 1'b1;
            end else if (is_shift_op(cmd_op) && (cmd_cnt != '0)) begin
              state_reg <= ST_SHIFT;
              busy_reg  <= 1'b1;
            end else begin
              // NOP, zero-count shift and illegal ops complete without touching the register
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
              err_reg   <= is_illegal_op(cmd_op);
            end
          end
        end
        ST_LOAD: begin
          if (step_en) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (step_en && term) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          err_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = (state_reg == ST_IDLE);
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign load_strobe = (state_reg == ST_LOAD) && step_en;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_par
      assign par_in[gi] = load_strobe & data_reg[gi];
    end
  endgenerate

  // Rotates feed the register's own end bit back in; shifts use the latched fill
  always_comb begin
    sel_mux = DATA_WIDTH1'(SEL_HOLD);
    sr      = 1'b0;
    sl      = 1'b0;
    if (load_strobe) begin
      sel_mux = DATA_WIDTH1'(SEL_LOAD);
    end else if (state_reg == ST_SHIFT) begin
      case (op_reg)
        OP_SHR: begin
          sr = fill_reg;
          if (step_en) sel_mux = DATA_WIDTH1'(SEL_SHR);
        end
        OP_ROR: begin
          sr = q_in[0];
          if (step_en) sel_mux = DATA_WIDTH1'(SEL_SHR);
        end
        OP_SHL: begin
          sl = fill_reg;
          if (step_en) sel_mux = DATA_WIDTH1'(SEL_SHL);
        end
        OP_ROL: begin
          sl = q_in[DATA_WIDTH-1];
          if (step_en) sel_mux = DATA_WIDTH1'(SEL_SHL);
        end
        default: begin
          sel_mux = DATA_WIDTH1'(SEL_HOLD);
        end
      endcase
    end
  end

  assign unused_q_mid = ^q_in;

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Directed bench: sequencer driving a behavioural 4-bit universal shift
// register, with hand-computed expectations per scenario.
module tb_usr_cmd_sequencer;

  logic       i_clk = 1'b0;
  logic       clr = 1'b0;
  logic       step_en = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'b000;
  logic [2:0] cmd_cnt = 3'b000;
  logic [3:0] cmd_data = 4'b0000;
  logic       cmd_fill = 1'b0;
  logic [3:0] q_in;
  logic [1:0] sel_mux;
  logic       sr;
  logic       sl;
  logic [3:0] par_in;
  logic       busy;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;

  logic [3:0] q_reg = 4'b0000;

  always #5 i_clk = ~i_clk;

  // Behavioural universal shift register (4:1 mux per bit + DFF)
  always @(posedge i_clk) begin
    case (sel_mux)
      2'b01:   q_reg <= {sr, q_reg[3:1]};
      2'b10:   q_reg <= {q_reg[2:0], sl};
      2'b11:   q_reg <= par_in;
      default: q_reg <= q_reg;
    endcase
  end
  assign q_in = q_reg;

  usr_cmd_sequencer #(
    .DATA_WIDTH (4),
    .DATA_WIDTH1(2),
    .CNT_WIDTH  (3)
  ) dut (
    .i_clk    (i_clk),
    .clr      (clr),
    .step_en  (step_en),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_cnt  (cmd_cnt),
    .cmd_data (cmd_data),
    .cmd_fill (cmd_fill),
    .q_in     (q_in),
    .sel_mux  (sel_mux),
    .sr       (sr),
    .sl       (sl),
    .par_in   (par_in),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic accept(input logic [2:0] op, input logic [2:0] cnt,
                        input logic [3:0] data, input logic fill);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_data  = data;
    cmd_fill  = fill;
    $display("cmd op=%b cnt=%0d data=%b fill=%b q=%b t=%0t", op, cnt, data, fill, q_reg, $time);
    tick();
    cmd_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    step_en = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 3'b001;
    tick();
    tick();
    checks++; if (sel_mux !== 2'b00) begin errors++; $display("FAIL reset_sel got=%b exp=00", sel_mux); end
    checks++; if ({sr, sl, par_in} !== 6'b0) begin errors++; $display("FAIL reset_serial_par got=%b exp=000000", {sr, sl, par_in}); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {busy, done, err}); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    cmd_valid = 1'b0;
    cmd_op = 3'b000;
    clr = 1'b1;
    tick();
    $display("reset released t=%0t", $time);
  endtask

  task automatic test_load();
    step_en = 1'b1;
    accept(3'b001, 3'd0, 4'b1010, 1'b0);
    checks++; if (sel_mux !== 2'b11) begin errors++; $display("FAIL load_sel got=%b exp=11", sel_mux); end
    checks++; if (par_in !== 4'b1010) begin errors++; $display("FAIL load_par got=%b exp=1010", par_in); end
    checks++; if ({busy, cmd_ready} !== 2'b10) begin errors++; $display("FAIL load_busy_ready got=%b exp=10", {busy, cmd_ready}); end
    tick();
    checks++; if (q_reg !== 4'b1010) begin errors++; $display("FAIL load_q got=%b exp=1010", q_reg); end
    checks++; if ({busy, done, err} !== 3'b010) begin errors++; $display("FAIL load_done got=%b exp=010", {busy, done, err}); end
    tick();
    checks++; if ({done, cmd_ready} !== 2'b01) begin errors++; $display("FAIL load_idle got=%b exp=01", {done, cmd_ready}); end
  endtask

  task automatic test_shr();
    step_en = 1'b1;
    accept(3'b010, 3'd2, 4'b0000, 1'b1);
    checks++; if ({sel_mux, sr, sl} !== 4'b0110) begin errors++; $display("FAIL shr_sel_serial got=%b exp=0110", {sel_mux, sr, sl}); end
    tick();
    checks++; if (q_reg !== 4'b1101) begin errors++; $display("FAIL shr_step1 got=%b exp=1101", q_reg); end
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL shr_mid_flags got=%b exp=10", {busy, done}); end
    tick();
    checks++; if (q_reg !== 4'b1110) begin errors++; $display("FAIL shr_step2 got=%b exp=1110", q_reg); end
    checks++; if ({busy, done, err} !== 3'b010) begin errors++; $display("FAIL shr_done got=%b exp=010", {busy, done, err}); end
    tick();
  endtask

  task automatic test_rol_gated();
    logic [3:0] exp_q [3];
    logic       exp_sl [3];
    int strobes;
    exp_q[0] = 4'b0011; exp_q[1] = 4'b0110; exp_q[2] = 4'b1100;
    exp_sl[0] = 1'b1;   exp_sl[1] = 1'b0;   exp_sl[2] = 1'b0;
    step_en = 1'b1;
    accept(3'b001, 3'd0, 4'b1001, 1'b0);
    tick();
    tick();
    checks++; if (q_reg !== 4'b1001) begin errors++; $display("FAIL rol_preload got=%b exp=1001", q_reg); end
    step_en = 1'b0;
    accept(3'b101, 3'd3, 4'b0000, 1'b0);
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      step_en = (i % 4 == 3);
      #1;
      checks++;
      if (sel_mux !== (step_en ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL rol_sel cyc=%0d got=%b exp=%b", i, sel_mux, step_en ? 2'b10 : 2'b00);
      end
      if (step_en) begin
        checks++; if (sl !== exp_sl[strobes]) begin errors++; $display("FAIL rol_sl strobe=%0d got=%b exp=%b", strobes, sl, exp_sl[strobes]); end
      end
      tick();
      if (step_en) begin
        strobes++;
        checks++; if (q_reg !== exp_q[strobes-1]) begin errors++; $display("FAIL rol_q strobe=%0d got=%b exp=%b", strobes, q_reg, exp_q[strobes-1]); end
        checks++; if (done !== (strobes == 3)) begin errors++; $display("FAIL rol_done strobe=%0d got=%b exp=%b", strobes, done, strobes == 3); end
      end
    end
    step_en = 1'b0;
    tick();
  endtask

  task automatic test_zero_nop();
    step_en = 1'b1;
    accept(3'b011, 3'd0, 4'b0000, 1'b1);
    checks++; if ({busy, done, sel_mux} !== 4'b0100) begin errors++; $display("FAIL zero_done got=%b exp=0100", {busy, done, sel_mux}); end
    tick();
    checks++; if ({q_reg, done} !== 5'b11000) begin errors++; $display("FAIL zero_q got=%b exp=11000", {q_reg, done}); end
    accept(3'b000, 3'd5, 4'b1111, 1'b1);
    checks++; if ({busy, done, err, sel_mux} !== 5'b01000) begin errors++; $display("FAIL nop_done got=%b exp=01000", {busy, done, err, sel_mux}); end
    tick();
    checks++; if (q_reg !== 4'b1100) begin errors++; $display("FAIL nop_q got=%b exp=1100", q_reg); end
  endtask

  task automatic test_illegal_back_to_back();
    step_en = 1'b1;
    accept(3'b111, 3'd3, 4'b0000, 1'b0);
    checks++; if ({done, err, busy} !== 3'b110) begin errors++; $display("FAIL illegal_flags got=%b exp=110", {done, err, busy}); end
    // Present the next command while still in DONE: it must wait for IDLE
    cmd_valid = 1'b1;
    cmd_op = 3'b001;
    cmd_data = 4'b0101;
    $display("cmd op=001 data=0101 presented during DONE t=%0t", $time);
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL illegal_ready_done got=%b exp=0", cmd_ready); end
    tick();
    checks++; if ({cmd_ready, err, q_reg} !== 6'b101100) begin errors++; $display("FAIL illegal_idle got=%b exp=101100", {cmd_ready, err, q_reg}); end
    tick();
    cmd_valid = 1'b0;
    #1;
    checks++; if ({sel_mux, busy} !== 3'b111) begin errors++; $display("FAIL b2b_load got=%b exp=111", {sel_mux, busy}); end
    tick();
    checks++; if ({q_reg, done} !== 5'b01011) begin errors++; $display("FAIL b2b_q got=%b exp=01011", {q_reg, done}); end
    tick();
  endtask

  task automatic test_abort();
    step_en = 1'b1;
    accept(3'b100, 3'd7, 4'b0000, 1'b0);
    checks++; if ({sel_mux, sr} !== 3'b011) begin errors++; $display("FAIL abort_ror_sel got=%b exp=011", {sel_mux, sr}); end
    tick(); tick(); tick();
    checks++; if ({q_reg, busy} !== 5'b10101) begin errors++; $display("FAIL abort_q3 got=%b exp=10101", {q_reg, busy}); end
    clr = 1'b0;
    $display("abort clr asserted t=%0t", $time);
    #1;
    checks++; if ({sel_mux, busy, done, cmd_ready} !== 5'b00001) begin errors++; $display("FAIL abort_immediate got=%b exp=00001", {sel_mux, busy, done, cmd_ready}); end
    tick();
    checks++; if (q_reg !== 4'b1010) begin errors++; $display("FAIL abort_hold got=%b exp=1010", q_reg); end
    clr = 1'b1;
    tick();
    checks++; if ({done, cmd_ready} !== 2'b01) begin errors++; $display("FAIL abort_release got=%b exp=01", {done, cmd_ready}); end
    accept(3'b001, 3'd0, 4'b0011, 1'b0);
    tick();
    checks++; if ({q_reg, done} !== 5'b00111) begin errors++; $display("FAIL abort_reload got=%b exp=00111", {q_reg, done}); end
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_load();
    test_shr();
    test_rol_gated();
    test_zero_nop();
    test_illegal_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
